// File: rtl/lut_table_loader_if.sv
// lut_table_loader_if
//   Bundles the table-write stream and the lookup port of lut_table_loader.
//   Write side : load_start, wr_valid, wr_data -> wr_ready, load_done, lut_valid
//   Lookup side: in_valid, M0                   -> out_valid, M1
//   modport slave  : the loader itself
//   modport master : the host/config path and layer slot driving it
interface lut_table_loader_if #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2,
  parameter int EPB      = 4
);
  logic                    load_start;
  logic                    wr_valid;
  logic [OUT_BITS*EPB-1:0] wr_data;
  logic                    wr_ready;
  logic                    load_done;
  logic                    lut_valid;
  logic                    in_valid;
  logic [IN_BITS-1:0]      M0;
  logic                    out_valid;
  logic [OUT_BITS-1:0]     M1;

  modport slave (
    input  load_start, wr_valid, wr_data, in_valid, M0,
    output wr_ready, load_done, lut_valid, out_valid, M1
  );

  modport master (
    output load_start, wr_valid, wr_data, in_valid, M0,
    input  wr_ready, load_done, lut_valid, out_valid, M1
  );
endinterface

// File: rtl/lut_table_loader.sv
// lut_table_loader
//   Runtime-loadable neuron truth table. A full 2^IN_BITS x OUT_BITS table is
//   streamed in EPB entries per beat, then served as registered lookups
//   (M0 -> M1, one cycle latency, one lookup per cycle).
// Ports
//   clk      : rising-edge clock
//   rst      : async active-high reset
//   bus      : lut_table_loader_if.slave (write stream + lookup port)
//   load_chk : XOR of every entry written in the current load
//              (only when LUT_LOAD_CHECKSUM_EN is defined)
// Configuration
//   LUT_LOAD_CHECKSUM_EN : adds the load_chk output and its checksum logic.
module lut_table_loader #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2,
  parameter int EPB      = 4
) (
  input  logic clk,
  input  logic rst,
  lut_table_loader_if.slave bus
`ifdef LUT_LOAD_CHECKSUM_EN
  ,
  output logic [OUT_BITS-1:0] load_chk
`endif
);

  localparam int DEPTH  = 1 << IN_BITS;
  localparam int BEATS  = DEPTH / EPB;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int KW     = $clog2(EPB);
  localparam int CW     = (KW > 0) ? KW : 1;
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  // One RAM row holds exactly one write beat, so a beat is a single row write
  // and the entry order inside wr_data matches the packed row layout.
  typedef logic [EPB-1:0][OUT_BITS-1:0] row_t;

  state_t              state, state_nxt;
  logic [BW-1:0]       cnt, cnt_nxt;
  logic                done_nxt;
  logic                wr_ready_q, lut_valid_q, load_done_q;
  logic                accept, last_beat;

  row_t                mem [BEATS];
  logic [BW-1:0]       rd_row;
  logic [CW-1:0]       rd_col;
  logic                lkp_fire;
  logic [STAGES:1]     vld_pipe;
  logic [OUT_BITS-1:0] m1_q;

  // A beat arriving with load_start belongs to the stream being abandoned.
  assign accept    = (state == LOAD) & bus.wr_valid & ~bus.load_start;
  assign last_beat = (cnt == BW'(BEATS - 1));

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (bus.load_start) begin
          cnt_nxt = '0;
        end else if (accept) begin
          if (last_beat) begin
            state_nxt = READY;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + BW'(1);
          end
        end
      end
      READY: begin
        if (bus.load_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Status outputs are dedicated flops loaded from the next state, so they
  // never glitch on a state-encoding decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_ready_q  <= 1'b0;
      lut_valid_q <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      wr_ready_q  <= (state_nxt == LOAD);
      lut_valid_q <= (state_nxt == READY);
      load_done_q <= done_nxt;
    end
  end

  assign bus.wr_ready  = wr_ready_q;
  assign bus.lut_valid = lut_valid_q;
  assign bus.load_done = load_done_q;

  // ---------------------------------------------------------------- RAM
  // Contents are deliberately not reset; lut_valid gates every use.
  always_ff @(posedge clk) begin
    if (accept) mem[cnt] <= bus.wr_data;
  end

  // ---------------------------------------------------------------- lookup
  assign rd_row   = BW'(bus.M0 >> KW);
  assign rd_col   = CW'(bus.M0 & IN_BITS'(EPB - 1));
  assign lkp_fire = bus.in_valid & lut_valid_q;

  // On a load_start edge no write is accepted, so a lookup sampled there
  // reads the old table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      m1_q     <= '0;
    end else begin
      vld_pipe[1] <= lkp_fire;
      if (lkp_fire) m1_q <= mem[rd_row][rd_col];
    end
  end

  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.M1        = m1_q;

`ifdef LUT_LOAD_CHECKSUM_EN
  // ---------------------------------------------------------------- checksum
  logic [OUT_BITS-1:0] beat_xor, chk_q;

  always_comb begin
    beat_xor = '0;
    for (int k = 0; k < EPB; k++) beat_xor ^= bus.wr_data[k*OUT_BITS +: OUT_BITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 chk_q <= '0;
    else if (bus.load_start) chk_q <= '0;
    else if (accept)         chk_q <= chk_q ^ beat_xor;
  end

  assign load_chk = chk_q;
`endif

endmodule
